fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
Downstream consumer of rect_draw's pixel stream (px, py, pixel_color, pixel_valid, done). It clips each pixel to the framebuffer, converts RGB888 to RGB565 and computes the linear address. Results are buffered in a small FIFO and written to framebuffer memory through a valid/ready write port. It also performs a full-screen clear and reports when a shape's pixels are fully committed.

Parameters:
FB_W, 64, framebuffer width in pixels
FB_H, 48, framebuffer height in pixels
ADDR_W, 12, memory address width; must satisfy 2^ADDR_W >= FB_W*FB_H
FIFO_DEPTH, 8, write-buffer entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
pixel_valid  in  1  pixel strobe from rect_draw; no backpressure exists
px  in  8  pixel x
py  in  8  pixel y
pixel_color  in  24  RGB888 {R,G,B}
draw_done  in  1  rect_draw done pulse
clear_start  in  1  request full-screen clear
clear_color  in  24  RGB888 clear colour, sampled with clear_start
mem_we  out  1  write request
mem_addr  out  ADDR_W  write address
mem_wdata  out  16  RGB565 data
mem_ready  in  1  memory accepts the write when mem_we && mem_ready
busy  out  1  writer has pending work
overflow  out  1  sticky flag: a pixel was dropped
clipped_cnt  out  16  saturating count of off-screen pixels
flush_done  out  1  one-cycle pulse: all pixels up to draw_done committed

Behaviour:
- Reset (async): all outputs 0, FIFO empty, S1 invalid, state RUN, pending flags cleared. mem_we drops immediately, including mid-clear or mid-drain; buffered pixels are discarded.
- S1 input register, in RUN state:
  - pixel_valid with px<FB_W and py<FB_H: S1 captures addr = py*FB_W+px (ADDR_W bits) and rgb565 = {c[23:19], c[15:10], c[7:3]}.
  - Off-screen pixel: clipped_cnt increments and saturates at 16'hFFFF; nothing is captured.
- FIFO push: valid S1 pushes at the next edge.
  - FIFO full with no pop in the same cycle: the entry is dropped and overflow is set.
  - Push and pop in the same cycle while full is legal; nothing is dropped.
- Latency: a pixel sampled at edge N is FIFO head after edge N+1, so mem_we is high in the cycle following N+1 when the FIFO was empty.
- Output is first-word fall-through.
  - mem_we = state RUN && !fifo_empty; mem_addr/mem_wdata = FIFO head.
  - Pop when mem_we && mem_ready.
  - While mem_we && !mem_ready, addr and data are held stable.
- States:
  - RUN: default. Drains the FIFO. clear_start is accepted only when FIFO empty and S1 invalid; it latches clear_color as RGB565, zeroes the clear counter, clears overflow and goes to CLEAR. clear_start in any other condition is ignored.
  - CLEAR: mem_we=1, mem_addr = counter, mem_wdata = clear colour. The counter advances on each accepted write. After address FB_W*FB_H-1 is accepted, return to RUN. pixel_valid in CLEAR is dropped and sets overflow. draw_done in CLEAR is still recorded.
- busy = (state==CLEAR) || S1 valid || !fifo_empty.
- draw_done:
  - Sets flush_pending.
  - flush_done pulses for one cycle in the first cycle where flush_pending && state==RUN && !S1 valid && fifo_empty; flush_pending then clears.
  - draw_done coinciding with the last pixel_valid still covers that pixel.
  - A second draw_done while pending merges; only one pulse is produced.

Decomposition:
- Package fb_pkg:
  - FB_W/FB_H defaults
  - rgb888_to_565 function
  - writer state enum {RUN, CLEAR}
  - fb_entry_t struct {addr, rgb565}
- Sub-module fb_sync_fifo: parameterised sync FIFO with FWFT head, full/empty and async reset.
- The writer contains S1, the FSM, the counters and the output mux.

Test Plan:
- Blue 24'h0000FF rect, x 10..14, y 20..22, mem_ready=1 -> 15 writes, row-major. First addr 1290, last 1422, wdata 16'h001F. flush_done is a single pulse after the last write. overflow=0.
- Red pixel (5,5) 24'hFF0000 -> one write, addr 325, wdata 16'hF800. Pixels (64,0) and (0,48) -> no writes, clipped_cnt=2.
- mem_ready=0 while 15 on-screen pixels stream -> overflow=1 and mem_addr/mem_wdata stable during the stall. After mem_ready=1, exactly 8 writes of the first 8 pixels in order; busy returns to 0.
- clear_start with 24'h00FF00 when idle -> 3072 writes, addr 0..3071 consecutive, wdata 16'h07E0. busy high throughout; pixel_valid during the clear sets overflow.
- With mem_ready toggling every other cycle, clear_start while FIFO non-empty -> the request is ignored, the FIFO drains normally and no clear writes occur.
- rst asserted mid-CLEAR at addr 100 -> mem_we=0 without waiting for a clock edge. After release: busy=0, clipped_cnt=0, overflow=0, and a new pixel writes normally.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer pixel writer.
package fb_pkg;

  localparam int FB_W_DEF   = 64;
  localparam int FB_H_DEF   = 48;
  localparam int ADDR_W_DEF = 12;
  // Buffered entries carry a 16-bit address field so ADDR_W may grow up to 16.
  localparam int ENT_ADDR_W = 16;

  typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} wr_state_e;

  typedef struct packed {
    logic [ENT_ADDR_W-1:0] addr;
    logic [15:0]           rgb565;
  } fb_entry_t;

  // RGB888 {R,G,B} -> RGB565 by truncating the low bits of each channel.
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] c);
    logic unused_lsbs;
    unused_lsbs = ^{c[18:16], c[9:8], c[2:0]};
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head.
// A push while full is dropped unless a pop happens in the same cycle.
module fb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Clips pixels to the framebuffer, converts to RGB565, buffers them and
// writes them out through a valid/ready port. Also runs full-screen clears
// and signals when all pixels of a shape have been committed.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  input  logic [7:0]        px,
  input  logic [7:0]        py,
  input  logic [23:0]       pixel_color,
  input  logic              draw_done,
  input  logic              clear_start,
  input  logic [23:0]       clear_color,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       clipped_cnt,
  output logic              flush_done
);
  localparam int NPIX = FB_W * FB_H;

  wr_state_e         state, state_nxt;
  logic              s1_vld;
  fb_entry_t         s1_entry;
  fb_entry_t         head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [ADDR_W-1:0] clr_cnt;
  logic [15:0]       clr_rgb;
  logic              flush_pending;
  logic              on_screen, capture, clear_acc, clear_last, drop;

  assign on_screen  = ({24'd0, px} < FB_W) && ({24'd0, py} < FB_H);
  assign capture    = (state == ST_RUN) && pixel_valid && on_screen;
  // A clear may only start once nothing is in flight, so no pixel is lost.
  assign clear_acc  = (state == ST_RUN) && clear_start && fifo_empty && !s1_vld;
  assign clear_last = (clr_cnt == ADDR_W'(NPIX - 1));
  assign fifo_pop   = (state == ST_RUN) && !fifo_empty && mem_ready;
  assign drop       = s1_vld && fifo_full && !fifo_pop;
  assign busy       = (state == ST_CLEAR) || s1_vld || !fifo_empty;
  assign flush_done = flush_pending && (state == ST_RUN) && !s1_vld && fifo_empty;

  fb_sync_fifo #(
    .WIDTH($bits(fb_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s1_vld),
    .din  (s1_entry),
    .pop  (fifo_pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // S1: register on-screen pixels with their linear address and RGB565 colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_vld <= capture;
      if (capture) begin
        s1_entry.addr   <= ENT_ADDR_W'({8'd0, py} * 16'(FB_W) + {8'd0, px});
        s1_entry.rgb565 <= rgb888_to_565(pixel_color);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state and write-port mux; address/data read 0 when not writing.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_RUN: begin
        if (clear_acc) state_nxt = ST_CLEAR;
        if (!fifo_empty) begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(head.addr);
          mem_wdata = head.rgb565;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = clr_rgb;
        if (mem_ready && clear_last) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Clear address counter and latched clear colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      clr_rgb <= '0;
    end else if (clear_acc) begin
      clr_cnt <= '0;
      clr_rgb <= rgb888_to_565(clear_color);
    end else if (state == ST_CLEAR && mem_ready) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Status: sticky overflow, saturating clip count, flush tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      clipped_cnt   <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (clear_acc)
        overflow <= 1'b0;
      else if (drop || (state == ST_CLEAR && pixel_valid))
        overflow <= 1'b1;
      if (state == ST_RUN && pixel_valid && !on_screen && clipped_cnt != 16'hFFFF)
        clipped_cnt <= clipped_cnt + 1'b1;
      // Multiple draw_done pulses before the flush merge into one.
      flush_pending <= draw_done || (flush_pending && !flush_done);
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: drawing, clipping, stall/overflow,
// full-screen clear, ignored clear and asynchronous reset mid-clear.
module tb_fb_pixel_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid, draw_done, clear_start, mem_ready;
  logic [7:0]  px, py;
  logic [23:0] pixel_color, clear_color;
  logic        mem_we, busy, overflow, flush_done;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, clipped_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int flush_cnt = 0;
  int flush_cyc = 0;
  int last_wr_cyc = 0;
  logic [27:0] wq[$];
  logic [27:0] exp_q[$];

  fb_pixel_writer dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .px(px), .py(py),
    .pixel_color(pixel_color), .draw_done(draw_done), .clear_start(clear_start),
    .clear_color(clear_color), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .overflow(overflow), .clipped_cnt(clipped_cnt), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted writes and flush pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      wq.push_back({mem_addr, mem_wdata});
      last_wr_cyc = cyc;
    end
    if (flush_done) begin
      flush_cnt++;
      flush_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] c, input logic dd);
    pixel_valid = 1'b1;
    px          = 8'(x);
    py          = 8'(y);
    pixel_color = c;
    draw_done   = dd;
    step();
    pixel_valid = 1'b0;
    draw_done   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step();
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int errs;
    int n;
    rst = 1'b1; pixel_valid = 0; draw_done = 0; clear_start = 0; mem_ready = 1;
    px = 0; py = 0; pixel_color = 0; clear_color = 0;
    repeat (3) step();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_clipped", clipped_cnt, 0);
    chk("rst_flush", flush_done, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    step();

    // Blue rectangle x 10..14, y 20..22, draw_done with last pixel.
    wq.delete(); exp_q.delete(); flush_cnt = 0;
    for (int y = 20; y <= 22; y++)
      for (int x = 10; x <= 14; x++) begin
        pix(x, y, 24'h0000FF, (x == 14 && y == 22));
        exp_q.push_back({12'(y * 64 + x), 16'h001F});
      end
    wait_idle("rect_idle", 50);
    repeat (3) step();
    chk("rect_count", wq.size(), 15);
    chk("rect_first", wq[0], {12'd1290, 16'h001F});
    chk("rect_last", wq[14], {12'd1422, 16'h001F});
    errs = 0;
    for (int i = 0; i < 15; i++) if (wq[i] !== exp_q[i]) errs++;
    chk("rect_order", errs, 0);
    chk("rect_flush_cnt", flush_cnt, 1);
    chk("rect_flush_after_wr", (flush_cyc > last_wr_cyc), 1);
    chk("rect_overflow", overflow, 0);

    // Single red pixel plus two off-screen pixels.
    wq.delete();
    pix(5, 5, 24'hFF0000, 0);
    pix(64, 0, 24'hFF0000, 0);
    pix(0, 48, 24'hFF0000, 0);
    wait_idle("red_idle", 20);
    repeat (2) step();
    chk("red_count", wq.size(), 1);
    chk("red_entry", wq[0], {12'd325, 16'hF800});
    chk("clip_cnt", clipped_cnt, 2);

    // Stall: 15 pixels while memory not ready; FIFO holds 8.
    wq.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pix(i, 1, 24'h123456, 0);
      if (i == 2 || i == 8 || i == 14) begin
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, 64);
        chk("stall_data", mem_wdata, 16'h11AA);
      end
    end
    step(); step();
    chk("stall_overflow", overflow, 1);
    chk("stall_hold_addr", mem_addr, 64);
    chk("stall_no_wr", wq.size(), 0);
    mem_ready = 1'b1;
    wait_idle("stall_idle", 30);
    repeat (2) step();
    chk("stall_count", wq.size(), 8);
    errs = 0;
    for (int i = 0; i < 8; i++) if (wq[i] !== {12'(64 + i), 16'h11AA}) errs++;
    chk("stall_order", errs, 0);

    // Full-screen clear to green.
    wq.delete();
    clear_start = 1'b1; clear_color = 24'h00FF00;
    step();
    clear_start = 1'b0;
    n = 0;
    chk("clr_ovf_cleared", overflow, 0);
    chk("clr_busy", busy, 1);
    pix(3, 3, 24'hFFFFFF, 0);
    n++;
    chk("clr_pixel_ovf", overflow, 1);
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      step();
      n++;
    end
    chk("clr_busy_cycles", n, 3072);
    step();
    chk("clr_count", wq.size(), 3072);
    errs = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== {12'(i), 16'h07E0}) errs++;
    chk("clr_seq", errs, 0);

    // Clear requested while FIFO non-empty is ignored.
    wq.delete();
    mem_ready = 1'b0;
    pix(1, 2, 24'h0000FF, 0);
    pix(2, 2, 24'h0000FF, 0);
    pix(3, 2, 24'h0000FF, 0);
    clear_start = 1'b1; clear_color = 24'h00FF00;
    step();
    clear_start = 1'b0;
    chk("ign_head", mem_wdata, 16'h001F);
    for (int i = 0; i < 60; i++) begin
      mem_ready = (i % 2 == 1);
      step();
      if (!busy) break;
    end
    mem_ready = 1'b1;
    chk("ign_busy", busy, 0);
    step(); step();
    chk("ign_we", mem_we, 0);
    chk("ign_count", wq.size(), 3);
    chk("ign_first", wq[0], {12'd129, 16'h001F});
    chk("ign_last", wq[2], {12'd131, 16'h001F});

    // Reset asserted mid-clear at address 100.
    clear_start = 1'b1; clear_color = 24'hFFFFFF;
    step();
    clear_start = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 12'd100) break;
      n++;
    end
    chk("rstclr_reach100", mem_addr, 100);
    #1 rst = 1'b1;
    #1 chk("rstclr_we_async", mem_we, 0);
    chk("rstclr_busy_async", busy, 0);
    step();
    rst = 1'b0;
    step();
    chk("rstclr_busy", busy, 0);
    chk("rstclr_clip", clipped_cnt, 0);
    chk("rstclr_ovf", overflow, 0);
    wq.delete();
    pix(5, 5, 24'hFF0000, 0);
    wait_idle("rstclr_idle", 20);
    repeat (2) step();
    chk("rstclr_new_count", wq.size(), 1);
    chk("rstclr_new_entry", wq[0], {12'd325, 16'hF800});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
